boot_loader: RTL and testbench
==============================

# boot_loader

Upstream stage of the core's 16 KB instruction/data RAM. It receives a program image as a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. It writes each word into the RAM's data write port and checks a trailing XOR checksum. On success it releases the core from hold; on any protocol error it latches an error flag and keeps the core held.

## Interface

Parameters:
- `BASE`, 14'h0000, byte address of the first loaded word; must be word-aligned.
- `MAX_WORDS`, 4096, largest accepted image length in words.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  a byte is offered on `in_data`.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  the loader accepts a byte this cycle.
- `wr_addr`  out  14  RAM byte address; always word-aligned.
- `wr_data`  out  32  RAM write word.
- `wr_size`  out  2  2'b11 = write a full word this cycle; 2'b00 = no write. Other codes are never driven.
- `core_hold`  out  1  1 holds the core in reset; 0 releases it.
- `done`  out  1  the image loaded and the checksum matched.
- `error`  out  1  the load was aborted; sticky until reset.
- `word_count`  out  13  number of payload words written so far.

## Operation

- **Stream format:** 4 length bytes (LSB first, giving N = word count), then 4·N payload bytes (each word LSB first), then 1 checksum byte. The checksum is the XOR of all payload bytes.
- **Handshake:** a byte transfers when `in_valid && in_ready` at a rising edge. `in_valid` may drop between bytes with no effect.
- **States:**
  - S_LEN: `in_ready`=1. Shift 4 bytes into the length register. After the 4th byte:
    - if N > MAX_WORDS, go to S_ERR;
    - if N == 0, go to S_SUM;
    - otherwise go to S_DATA.
  - S_DATA: `in_ready`=1.
    - Shift each byte into a word register and XOR it into the running checksum; a 2-bit byte index tracks position.
    - When the 4th byte of a word is accepted, issue one write on the next cycle and increment `word_count` in that same cycle.
    - After word N is accepted, go to S_SUM.
  - S_SUM: `in_ready`=1. Compare the accepted byte with the running checksum. A match goes to S_DONE; a mismatch goes to S_ERR.
  - S_DONE: `in_ready`=0, `done`=1, `core_hold`=0. Terminal state.
  - S_ERR: `in_ready`=0, `error`=1, `core_hold`=1. Terminal state.
- **Write address:** `wr_addr` = (BASE + 4·k) mod 2^14 for word k (0-based). It wraps silently; with BASE=0 and MAX_WORDS=4096 it covers the whole RAM exactly.
- **Length width:** the length register is 32 bits. Any nonzero bits above bit 12 count as N > MAX_WORDS.
- **Only exit from terminal states** is `resetn`. Bytes offered in S_DONE or S_ERR are never accepted.
- **Reset mid-load:** all state returns to S_LEN and the checksum clears. RAM words already written are left as-is. Any write pulse in flight is dropped, because `wr_size` resets asynchronously.

## Timing

- **Reset values while `resetn`=0:**
  - `in_ready`=0, `wr_size`=2'b00;
  - `wr_addr`=BASE, `wr_data`=0;
  - `core_hold`=1, `done`=0, `error`=0, `word_count`=0.
- **First cycle after `resetn` rises:** `in_ready`=1.
- **Write latency:** `wr_size`=2'b11 for exactly one cycle, the cycle after the edge that accepted a word's 4th byte. `wr_addr`/`wr_data` hold stable for that cycle. Consecutive words can write every 4 cycles at full input rate.
- **Final-word overlap:** the last payload write may coincide with S_SUM accepting the checksum byte. Both happen; the write is never suppressed.
- **Checksum latency:** `done` or `error` and `core_hold` update on the edge after the checksum byte is accepted, i.e. one cycle later.
- **Length-error latency:** `error` asserts one cycle after the 4th length byte.
- **Output registers:** all outputs are registers. `in_ready` is decoded from the state register only, with no combinational path from `in_valid`.

## Test plan

1. **Two-word load:** stream 02 00 00 00, 93 00 00 00, 78 56 34 12, 9B at full rate. Expect two writes: addr 0x0000 data 0x00000093, then addr 0x0004 data 0x12345678, each with `wr_size`=11 for 1 cycle. Then `done`=1, `core_hold`=0, `word_count`=2.
2. **Checksum mismatch:** the same stream with trailer 9A. Both writes still occur; then `error`=1, `core_hold`=1, `in_ready`=0, and `done` stays 0.
3. **Empty image:** stream 00 00 00 00, 00. Expect no write, `done`=1 one cycle after the 5th byte, `word_count`=0.
4. **Oversize length:** stream 01 10 00 00 (N=4097). Expect `error`=1 one cycle later and `in_ready`=0. Any further bytes are ignored and no writes occur.
5. **Gapped input:** scenario 1 with `in_valid` toggling 1,0,0,1… Expect identical writes and result, and that no byte is duplicated or lost.
6. **Reset mid-load:** pulse `resetn` low for 1 cycle after the 6th byte of scenario 1, then replay the full stream. Expect all outputs at their reset values during the pulse, the first write landing at 0x0000 again, and `done`=1 at the end.

Source files
------------

// File: rtl/boot_loader.sv
// boot_loader: loads a program image from a byte stream into the core RAM.
//
// Stream: 4 length bytes (LSB first, N words), 4*N payload bytes (each word
// LSB first), 1 checksum byte (XOR of all payload bytes). Each assembled word
// is written to the RAM write port one cycle after its last byte is accepted.
// A matching checksum releases the core; any protocol error holds it for good.
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   in_valid/in_data     byte offered by the upstream source
//   in_ready             loader accepts a byte this cycle (registered)
//   wr_addr/wr_data      RAM byte address (word-aligned) and write word
//   wr_size              2'b11 = write this cycle, 2'b00 = idle
//   core_hold            1 keeps the core in reset
//   done / error         image loaded and verified / load aborted (sticky)
//   word_count           payload words written so far
`timescale 1ns/1ps
module boot_loader #(
   parameter logic [13:0] BASE      = 14'h0000,
   parameter int unsigned MAX_WORDS = 4096
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic [13:0] wr_addr,
   output logic [31:0] wr_data,
   output logic [1:0]  wr_size,
   output logic        core_hold,
   output logic        done,
   output logic        error,
   output logic [12:0] word_count
);

   typedef enum logic [2:0] {
      S_LEN  = 3'd0,
      S_DATA = 3'd1,
      S_SUM  = 3'd2,
      S_DONE = 3'd3,
      S_ERR  = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic [23:0] len_q, len_d;      // first three length bytes, LSB lowest
   logic [12:0] n_q, n_d;          // accepted image length in words
   logic [23:0] word_q, word_d;    // first three bytes of the current word
   logic [7:0]  csum_q, csum_d;
   logic [13:0] wr_addr_q, wr_addr_d;
   logic [31:0] wr_data_q, wr_data_d;
   logic [1:0]  wr_size_q, wr_size_d;
   logic [12:0] word_count_q, word_count_d;
   logic        in_ready_q, in_ready_d;
   logic        done_q, done_d;
   logic        error_q, error_d;
   logic        core_hold_q, core_hold_d;

   logic        take_s;
   logic        last_byte_s;
   logic [31:0] len_full_s;
   logic [31:0] word_full_s;

   // Running XOR checksum over payload bytes.
   function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction

   // in_ready_q mirrors the state register, so a transfer never depends
   // combinationally on in_valid for the ready decision.
   assign take_s      = in_valid && in_ready_q;
   assign last_byte_s = (idx_q == 2'd3);
   assign len_full_s  = {in_data, len_q};
   assign word_full_s = {in_data, word_q};

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_LEN;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_LEN: begin
            if (take_s && last_byte_s) begin
               // The 32-bit compare also catches any bit set above bit 12.
               if (len_full_s > MAX_WORDS) begin
                  state_d = S_ERR;
               end else if (len_full_s == 32'd0) begin
                  state_d = S_SUM;
               end else begin
                  state_d = S_DATA;
               end
            end else begin
               state_d = S_LEN;
            end
         end
         S_DATA: begin
            if (take_s && last_byte_s && ((word_count_q + 13'd1) == n_q)) begin
               state_d = S_SUM;
            end else begin
               state_d = S_DATA;
            end
         end
         S_SUM: begin
            if (take_s) begin
               if (in_data == csum_q) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_ERR;
               end
            end else begin
               state_d = S_SUM;
            end
         end
         S_DONE:  state_d = S_DONE;
         S_ERR:   state_d = S_ERR;
         default: state_d = S_ERR;
      endcase
   end

   // Status outputs, registered from the next state so they track it exactly.
   always_comb begin
      in_ready_d  = 1'b0;
      done_d      = 1'b0;
      error_d     = 1'b0;
      core_hold_d = 1'b1;
      case (state_d)
         S_LEN, S_DATA, S_SUM: begin
            in_ready_d = 1'b1;
         end
         S_DONE: begin
            done_d      = 1'b1;
            core_hold_d = 1'b0;
         end
         S_ERR: begin
            error_d = 1'b1;
         end
         default: begin
            error_d = 1'b1;
         end
      endcase
   end

   // Datapath: length capture, word assembly, checksum and write issue.
   always_comb begin
      idx_d        = idx_q;
      len_d        = len_q;
      n_d          = n_q;
      word_d       = word_q;
      csum_d       = csum_q;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      wr_size_d    = 2'b00;
      word_count_d = word_count_q;
      case (state_q)
         S_LEN: begin
            if (take_s) begin
               idx_d = idx_q + 2'd1;
               len_d = {in_data, len_q[23:8]};
               if (last_byte_s) begin
                  n_d = len_full_s[12:0];
               end else begin
                  n_d = n_q;
               end
            end else begin
               idx_d = idx_q;
            end
         end
         S_DATA: begin
            if (take_s) begin
               idx_d  = idx_q + 2'd1;
               word_d = {in_data, word_q[23:8]};
               csum_d = csum_next(csum_q, in_data);
               if (last_byte_s) begin
                  // Write goes out next cycle; word_count steps with it.
                  wr_size_d    = 2'b11;
                  wr_data_d    = word_full_s;
                  wr_addr_d    = BASE + {word_count_q[11:0], 2'b00};
                  word_count_d = word_count_q + 13'd1;
               end else begin
                  wr_size_d = 2'b00;
               end
            end else begin
               idx_d = idx_q;
            end
         end
         S_SUM, S_DONE, S_ERR: begin
            idx_d = idx_q;
         end
         default: begin
            idx_d = idx_q;
         end
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         idx_q        <= 2'd0;
         len_q        <= 24'd0;
         n_q          <= 13'd0;
         word_q       <= 24'd0;
         csum_q       <= 8'd0;
         wr_addr_q    <= BASE;
         wr_data_q    <= 32'd0;
         wr_size_q    <= 2'b00;
         word_count_q <= 13'd0;
         in_ready_q   <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         core_hold_q  <= 1'b1;
      end else begin
         idx_q        <= idx_d;
         len_q        <= len_d;
         n_q          <= n_d;
         word_q       <= word_d;
         csum_q       <= csum_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         wr_size_q    <= wr_size_d;
         word_count_q <= word_count_d;
         in_ready_q   <= in_ready_d;
         done_q       <= done_d;
         error_q      <= error_d;
         core_hold_q  <= core_hold_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign wr_size    = wr_size_q;
   assign core_hold  = core_hold_q;
   assign done       = done_q;
   assign error      = error_q;
   assign word_count = word_count_q;

endmodule

// File: tb/tb_boot_loader.sv
`timescale 1ns/1ps
module tb_boot_loader;
   localparam logic [13:0] BASE = 14'h0000;
   localparam int MAXW = 4096;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_ready;
   logic [13:0] wr_addr;
   logic [31:0] wr_data;
   logic [1:0]  wr_size;
   logic        core_hold;
   logic        done;
   logic        error;
   logic [12:0] word_count;

   boot_loader #(.BASE(BASE), .MAX_WORDS(MAXW)) dut (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_size(wr_size),
      .core_hold(core_hold), .done(done), .error(error), .word_count(word_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [13:0] a;
      logic [31:0] d;
   } wr_t;

   int          checks = 0;
   int          errors = 0;
   wr_t         exp_q[$];
   logic [31:0] img_words[$];
   int          wr_seen = 0;
   bit          prev_wr = 1'b0;
   wr_t         mon_w;

   // Write monitor: every write must match the next expected (addr, data),
   // last exactly one cycle, and carry the updated word_count.
   always @(negedge clk) begin
      if (resetn) begin
         if (wr_size == 2'b11) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write addr=%h data=%h", wr_addr, wr_data);
            end else begin
               mon_w = exp_q.pop_front();
               if (wr_addr !== mon_w.a || wr_data !== mon_w.d) begin
                  errors++;
                  $display("FAIL write_content got addr=%h data=%h want addr=%h data=%h",
                           wr_addr, wr_data, mon_w.a, mon_w.d);
               end
            end
            checks++;
            if (word_count !== 13'(wr_seen + 1)) begin
               errors++;
               $display("FAIL word_count_at_write got=%0d want=%0d", word_count, wr_seen + 1);
            end
            checks++;
            if (prev_wr) begin
               errors++;
               $display("FAIL write_pulse_width got=2+ cycles want=1");
            end
            wr_seen++;
         end else if (wr_size !== 2'b00) begin
            checks++;
            errors++;
            $display("FAIL wr_size_code got=%b want=00 or 11", wr_size);
         end
         prev_wr = (wr_size == 2'b11);
      end else begin
         prev_wr = 1'b0;
      end
   end

   function automatic int gap_for(input int mode);
      if (mode == 0) return 0;
      else if (mode == 1) return 2;
      else return int'($urandom_range(0, 3));
   endfunction

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int t;
      for (int g = 0; g < gap; g++) begin
         in_valid = 1'b0;
         @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = b;
      t = 0;
      while (in_ready !== 1'b1 && t < 16) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (t >= 16) begin
         errors++;
         $display("FAIL ready_timeout got in_ready=%b want=1 within 16 cycles", in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      checks++;
      if (in_ready !== 1'b0 || wr_size !== 2'b00 || wr_addr !== BASE || wr_data !== 32'd0 ||
          core_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0 || word_count !== 13'd0) begin
         errors++;
         $display("FAIL reset_%s got rdy=%b sz=%b a=%h d=%h hold=%b done=%b err=%b wc=%0d want 0 00 %h 0 1 0 0 0",
                  tag, in_ready, wr_size, wr_addr, wr_data, core_hold, done, error, word_count, BASE);
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      #2;
      resetn   = 1'b0;
      in_valid = 1'b0;
      #1;
      check_reset_values("async");
      @(negedge clk);
      check_reset_values("held");
      exp_q.delete();
      wr_seen = 0;
      #2;
      resetn = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_reset got=%b want=1", in_ready);
      end
   endtask

   // Reference model: expected writes, checksum and outcome from the stream rules.
   task automatic load_image(input logic [31:0] len_field, input int trailer, input int gapmode);
      logic [7:0]  sum;
      logic [7:0]  tb_byte;
      logic [31:0] wv;
      wr_t         lw;
      bit          oversize;
      bit          exp_done;
      int          n;
      sum      = 8'h00;
      oversize = (len_field > 32'(MAXW));
      n        = oversize ? 0 : int'(len_field);
      for (int k = 0; k < n; k++) begin
         wv   = img_words[k];
         lw.a = 14'((int'(BASE) + 4 * k) % 16384);
         lw.d = wv;
         exp_q.push_back(lw);
         for (int j = 0; j < 4; j++) sum = sum ^ wv[8*j +: 8];
      end
      for (int j = 0; j < 4; j++) send_byte(8'(len_field >> (8 * j)), gap_for(gapmode));
      if (oversize) begin
         checks++;
         if (error !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0 || core_hold !== 1'b1) begin
            errors++;
            $display("FAIL len_error got err=%b rdy=%b done=%b hold=%b want 1 0 0 1",
                     error, in_ready, done, core_hold);
         end
      end else begin
         for (int k = 0; k < n; k++) begin
            wv = img_words[k];
            for (int j = 0; j < 4; j++) send_byte(wv[8*j +: 8], gap_for(gapmode));
         end
         checks++;
         if (done !== 1'b0 || error !== 1'b0 || core_hold !== 1'b1) begin
            errors++;
            $display("FAIL pre_trailer got done=%b err=%b hold=%b want 0 0 1", done, error, core_hold);
         end
         tb_byte  = (trailer < 0) ? sum : 8'(trailer);
         exp_done = (tb_byte == sum);
         send_byte(tb_byte, gap_for(gapmode));
         checks++;
         if (done !== exp_done || error !== !exp_done || core_hold !== !exp_done || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL result got done=%b err=%b hold=%b rdy=%b want %b %b %b 0",
                     done, error, core_hold, in_ready, exp_done, !exp_done, !exp_done);
         end
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL missing_writes got=%0d pending want=0", exp_q.size());
      end
      checks++;
      if (word_count !== 13'(n)) begin
         errors++;
         $display("FAIL final_word_count got=%0d want=%0d", word_count, n);
      end
   endtask

   task automatic offer_ignored(input int cycles, input logic exp_done, input int exp_n);
      for (int i = 0; i < cycles; i++) begin
         in_valid = 1'b1;
         in_data  = 8'($urandom);
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b0 || done !== exp_done || error !== !exp_done || word_count !== 13'(exp_n)) begin
            errors++;
            $display("FAIL terminal_hold got rdy=%b done=%b err=%b wc=%0d want 0 %b %b %0d",
                     in_ready, done, error, word_count, exp_done, !exp_done, exp_n);
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic set_scenario1();
      img_words.delete();
      img_words.push_back(32'h0000_0093);
      img_words.push_back(32'h1234_5678);
   endtask

   task automatic test_reset();
      apply_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || done !== 1'b0 || error !== 1'b0 || core_hold !== 1'b1 || word_count !== 13'd0) begin
         errors++;
         $display("FAIL idle_after_reset got rdy=%b done=%b err=%b hold=%b wc=%0d want 1 0 0 1 0",
                  in_ready, done, error, core_hold, word_count);
      end
   endtask

   task automatic test_two_word();
      apply_reset();
      set_scenario1();
      load_image(32'd2, 8'h9B, 0);
      offer_ignored(4, 1'b1, 2);
   endtask

   task automatic test_bad_checksum();
      apply_reset();
      set_scenario1();
      load_image(32'd2, 8'h9A, 0);
      offer_ignored(4, 1'b0, 2);
   endtask

   task automatic test_empty();
      apply_reset();
      img_words.delete();
      load_image(32'd0, 8'h00, 0);
   endtask

   task automatic test_oversize();
      apply_reset();
      load_image(32'h0000_1001, -1, 0);
      offer_ignored(8, 1'b0, 0);
      apply_reset();
      load_image(32'h8000_0001, -1, 2);
      offer_ignored(3, 1'b0, 0);
   endtask

   task automatic test_gapped();
      apply_reset();
      set_scenario1();
      load_image(32'd2, 8'h9B, 1);
   endtask

   task automatic test_reset_mid_load();
      logic [7:0] s [6];
      s = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00};
      apply_reset();
      for (int i = 0; i < 6; i++) send_byte(s[i], 0);
      apply_reset();
      set_scenario1();
      load_image(32'd2, 8'h9B, 0);
   endtask

   task automatic test_max_len();
      apply_reset();
      img_words.delete();
      for (int k = 0; k < MAXW; k++) img_words.push_back($urandom);
      load_image(32'(MAXW), -1, 0);
   endtask

   task automatic test_random();
      int n;
      int tr;
      for (int it = 0; it < 10; it++) begin
         apply_reset();
         n = int'($urandom_range(0, 6));
         img_words.delete();
         for (int k = 0; k < n; k++) img_words.push_back($urandom);
         tr = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 255));
         if (it == 9) load_image(32'(MAXW + 1) + 32'($urandom_range(0, 1000)), -1, 2);
         else load_image(32'(n), tr, 2);
      end
   endtask

   initial begin
      test_reset();
      test_two_word();
      test_bad_checksum();
      test_empty();
      test_oversize();
      test_gapped();
      test_reset_mid_load();
      test_back_to_back_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   task automatic test_back_to_back_random();
      test_random();
      test_max_len();
   endtask

endmodule
